button_conditioner: RTL and testbench

// Multi-channel switch/button conditioner between raw board pins and PL control logic.
// Per channel: synchroniser, stable-time debounce filter, polarity mask, edge pulses,
// and long-press detection with auto-repeat (e.g. OLED menu scroll).

---
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: synchroniser, tick-based debounce, polarity mask,
// edge pulses and long-press hold/auto-repeat per channel, sharing one prescaler tick.
module button_lane #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 16,
  parameter int   HOLD_TICKS   = 500,
  parameter int   REPEAT_TICKS = 100,
  parameter logic INV          = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic pin,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic rpt
);
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] R_LAST = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic [SW-1:0]          scnt;
  logic [HW-1:0]          hcnt;
  logic [RW-1:0]          rcnt;
  state_t                 state;
  logic                   s, accept;

  // Sync flops reset to the inactive pin level so every channel starts released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync <= {SYNC_STAGES{INV}};
    else         sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign s      = sync[SYNC_STAGES-1] ^ INV;
  assign accept = (s != out) && tick && (scnt == S_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scnt <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
      if (s == out) scnt <= '0;
      else if (tick) begin
        if (scnt == S_LAST) begin
          out  <= s;
          scnt <= '0;
        end else scnt <= scnt + 1'b1;
      end
    end
  end

  // An accepted release takes priority over any hold/repeat expiry in the same clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      hcnt  <= '0;
      rcnt  <= '0;
      hold  <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      hold <= 1'b0;
      rpt  <= 1'b0;
      if (accept && !s) begin
        state <= IDLE;
        hcnt  <= '0;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (accept && s) begin
            state <= PRESS;
            hcnt  <= '0;
          end
          PRESS: if (tick) begin
            if (hcnt == H_LAST) begin
              hold  <= 1'b1;
              rpt   <= 1'b1;
              rcnt  <= '0;
              state <= HELD;
            end else hcnt <= hcnt + 1'b1;
          end
          HELD: if (REPEAT_TICKS > 0 && tick) begin
            if (rcnt == R_LAST) begin
              rpt  <= 1'b1;
              rcnt <= '0;
            end else rcnt <= rcnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int               WIDTH        = 4,
  parameter int               SYNC_STAGES  = 2,
  parameter int               TICK_DIV     = 1024,
  parameter int               STABLE_TICKS = 16,
  parameter int               HOLD_TICKS   = 500,
  parameter int               REPEAT_TICKS = 100,
  parameter logic [WIDTH-1:0] INVERT       = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_out,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic [WIDTH-1:0] switch_hold,
  output logic [WIDTH-1:0] switch_repeat
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == P_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_lane
    button_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .INV         (INVERT[i])
    ) u_lane (
      .clk   (clk),
      .resetn(resetn),
      .tick  (tick),
      .pin   (switch_in[i]),
      .out   (switch_out[i]),
      .rise  (switch_rise[i]),
      .fall  (switch_fall[i]),
      .hold  (switch_hold[i]),
      .rpt   (switch_repeat[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, corner sequences (bounce, async reset,
// inverted channel, prescaled timing) and random stimulus against a window-based model.
module tb_button_conditioner;
  logic clk = 1'b0, resetn = 1'b0;
  logic [1:0] in_a = '0, in_b = '0, in_c = '0;
  logic [1:0] out_a, rise_a, fall_a, hold_a, rpt_a;
  logic [1:0] out_b, rise_b, fall_b, hold_b, rpt_b;
  logic [1:0] out_c, rise_c, fall_c, hold_c, rpt_c;

  always #5 clk = ~clk;

  button_conditioner #(.WIDTH(2), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4),
    .HOLD_TICKS(10), .REPEAT_TICKS(3), .INVERT(2'b00)) dut_a (
    .clk(clk), .resetn(resetn), .switch_in(in_a), .switch_out(out_a), .switch_rise(rise_a),
    .switch_fall(fall_a), .switch_hold(hold_a), .switch_repeat(rpt_a));

  button_conditioner #(.WIDTH(2), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4),
    .HOLD_TICKS(10), .REPEAT_TICKS(3), .INVERT(2'b10)) dut_b (
    .clk(clk), .resetn(resetn), .switch_in(in_b), .switch_out(out_b), .switch_rise(rise_b),
    .switch_fall(fall_b), .switch_hold(hold_b), .switch_repeat(rpt_b));

  button_conditioner #(.WIDTH(2), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(4),
    .HOLD_TICKS(10), .REPEAT_TICKS(0), .INVERT(2'b00)) dut_c (
    .clk(clk), .resetn(resetn), .switch_in(in_c), .switch_out(out_c), .switch_rise(rise_c),
    .switch_fall(fall_c), .switch_hold(hold_c), .switch_repeat(rpt_c));

  int n_pass = 0, n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time at the negedge just before edge 1 after release.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0] pin;
    int         cyc;
    logic [1:0] o, r, f, h, p;
  } vec_t;

  vec_t tv[15];

  // Reference model for dut_a: a new level is accepted once the last STABLE_TICKS
  // synchronised samples all disagree with the current output; hold/repeat follow press age.
  localparam int STB = 4, HLD = 10, REP = 3;
  bit   pq[2][$];
  bit   win[2][$];
  logic [1:0] mo, mr, mf, mh, mp;
  int   age[2];

  function automatic bit all_differ(input int ch, input bit cur);
    bit r = (win[ch].size() == STB);
    foreach (win[ch][k]) if (win[ch][k] == cur) r = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      pq[ch].delete();
      win[ch].delete();
      pq[ch].push_back(1'b0);
      pq[ch].push_back(1'b0);
      for (int k = 0; k < STB; k++) win[ch].push_back(1'b0);
      age[ch] = 0;
    end
    mo = '0; mr = '0; mf = '0; mh = '0; mp = '0;
  endtask

  task automatic model_edge(input logic [1:0] pins);
    for (int ch = 0; ch < 2; ch++) begin
      bit sp, acc;
      sp = pq[ch].pop_front();
      pq[ch].push_back(pins[ch]);
      win[ch].push_back(sp);
      if (win[ch].size() > STB) void'(win[ch].pop_front());
      acc = all_differ(ch, mo[ch]);
      mr[ch] = 1'b0; mf[ch] = 1'b0; mh[ch] = 1'b0; mp[ch] = 1'b0;
      if (acc) begin
        mo[ch] = ~mo[ch];
        if (mo[ch]) begin mr[ch] = 1'b1; age[ch] = 0; end
        else mf[ch] = 1'b1;
      end else if (mo[ch]) begin
        age[ch]++;
        if (age[ch] == HLD) begin mh[ch] = 1'b1; mp[ch] = 1'b1; end
        else if (age[ch] > HLD && (age[ch] - HLD) % REP == 0) mp[ch] = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, cnt_h, cnt_p, hold_at, c, exp_acc;
    logic [1:0] pinv;
    int runleft[2];

    tv[0]  = '{2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[1]  = '{2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    tv[2]  = '{2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[3]  = '{2'b01, 9, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    tv[4]  = '{2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[5]  = '{2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    tv[6]  = '{2'b01, 3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    tv[7]  = '{2'b00, 2, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[8]  = '{2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    tv[9]  = '{2'b00, 3, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[10] = '{2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[11] = '{2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[12] = '{2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[13] = '{2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    tv[14] = '{2'b00, 6, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};

    // Reset state
    #3;
    check("reset_a", {out_a, rise_a, fall_a, hold_a, rpt_a}, 32'h0);
    check("reset_c", {out_c, rise_c, fall_c, hold_c, rpt_c}, 32'h0);

    // Vector table on dut_a
    do_reset();
    foreach (tv[i]) begin
      in_a = tv[i].pin;
      step(tv[i].cyc);
      check($sformatf("vec%0d", i), {out_a, rise_a, fall_a, hold_a, rpt_a},
            {tv[i].o, tv[i].r, tv[i].f, tv[i].h, tv[i].p});
    end

    // Short pulse and bounce must never be accepted
    in_a = '0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      in_a[0] = ((k / 2) % 2) == 0;
      step(1);
      check("bounce", {out_a, rise_a, fall_a}, 32'h0);
    end
    in_a = 2'b01;
    step(3);
    in_a = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("pulse3", {out_a, rise_a, fall_a}, 32'h0);
    end

    // Inverted channel reads pressed after reset with pin low
    in_b = '0;
    do_reset();
    step(5);
    check("inv_e5", {out_b, rise_b}, 32'h0);
    step(1);
    check("inv_e6", {out_b, rise_b}, {2'b10, 2'b10});
    step(1);
    check("inv_e7", {out_b, rise_b}, {2'b10, 2'b00});

    // Async reset mid-HELD, then fresh press with pin still high
    in_a = '0;
    do_reset();
    in_a = 2'b01;
    lat = 0;
    while (lat < 40 && !hold_a[0]) begin step(1); lat++; end
    check("held_reach", lat, 16);
    step(1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_a", {out_a, rise_a, fall_a, hold_a, rpt_a}, 32'h0);
    check("async_rst_b", {out_b, rise_b, fall_b, hold_b, rpt_b}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    lat = 0;
    while (lat < 40 && !rise_a[0]) begin step(1); lat++; end
    check("rst_rise_lat", lat, 6);
    lat = 0;
    while (lat < 40 && !hold_a[0]) begin step(1); lat++; end
    check("rst_hold_lat", lat, 10);

    // Prescaled timing: tick on edges that are multiples of 4 after reset
    in_a = '0;
    for (int k = 0; k < 4; k++) begin
      in_c = '0;
      do_reset();
      step(k);
      in_c = 2'b01;
      c = k + 1;
      exp_acc = ((c + 2 + 3) / 4) * 4 + 12;
      lat = 0;
      while (lat < 40 && !out_c[0]) begin step(1); lat++; end
      check($sformatf("tdiv_lat%0d", k), lat - 1, exp_acc - c);
      check($sformatf("tdiv_rng%0d", k), (lat - 1 >= 14 && lat - 1 <= 17), 1);
      check($sformatf("tdiv_rise%0d", k), rise_c, 2'b01);
      if (k == 3) begin
        cnt_h = 0; cnt_p = 0; hold_at = -1;
        for (int t = 1; t <= 200; t++) begin
          step(1);
          if (hold_c[0]) begin cnt_h++; if (hold_at < 0) hold_at = t; end
          if (rpt_c[0]) cnt_p++;
        end
        check("norep_hold_at", hold_at, 40);
        check("norep_holds", cnt_h, 1);
        check("norep_repeats", cnt_p, 1);
      end
    end
    in_c = '0;

    // Random stimulus on dut_a against the model
    in_a = '0;
    do_reset();
    model_reset();
    runleft[0] = 0; runleft[1] = 0;
    pinv = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (runleft[ch] == 0) begin
          pinv[ch] = 1'($urandom_range(0, 1));
          runleft[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                    : int'($urandom_range(1, 7));
        end
        runleft[ch]--;
      end
      in_a = pinv;
      @(posedge clk);
      model_edge(in_a);
      #1;
      check("rand", {out_a, rise_a, fall_a, hold_a, rpt_a}, {mo, mr, mf, mh, mp});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
